gate_exerciser: RTL
===================

Name: gate_exerciser

Overview:
Stimulus-and-check stage wrapped around the two-input basic gate block. It drives a,b through all four input combinations and waits a programmable settle time per vector. It then samples the eight gate outputs, compares them against a golden truth table, and reports pass/fail, a mismatch count and per-gate sticky fail flags. Intended as the self-checking harness stage for gate-level bring-up and regression.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before sampling; must be >= 1 (elaboration-time check).
ITERATIONS, 1, number of full 4-vector sweeps per run; must be >= 1.
ERR_W, 8, width of err_count.

Ports:
clk  input  1  single clock, all logic rising-edge.
rst  input  1  synchronous, active-high reset.
start  input  1  run request; sampled only in IDLE.
a  output  1  stimulus to gate block.
b  output  1  stimulus to gate block.
resp_in  input  8  gate outputs: [0]and [1]or [2]xor [3]nand [4]nor [5]xnor [6]not_a [7]not_b.
busy  output  1  high from start acceptance until DONE.
done  output  1  one-cycle pulse at end of run.
pass  output  1  valid after done; 1 when err_count==0.
err_count  output  ERR_W  number of CHECK cycles with any mismatch, saturating.
fail_vec  output  8  sticky per-gate mismatch flags, bit order as resp_in.

Behaviour:
- Reset (sync, active-high, one clock domain): state=IDLE, a=b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, vector index=0, sweep=0. Reset mid-run aborts immediately; no done pulse.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE: busy=0. On edge E0 with start=1: {a,b}=2'b00, err_count=0, fail_vec=0, pass=0, settle counter=0, busy=1, go to SETTLE.
- SETTLE: hold {a,b}; after SETTLE_CYCLES cycles go to CHECK (transition at edge E0+SETTLE_CYCLES for vector 0).
- CHECK: one cycle. At its closing edge, sample resp_in and compare with expected(a,b). Any mismatch: err_count+=1 (saturate at 2^ERR_W-1); fail_vec |= mismatch bits.
  - If index==3 and sweep==ITERATIONS-1, go to DONE.
  - Otherwise index=index+1 (3 wraps to 0, sweep+=1), {a,b}=new index, go to SETTLE.
- Per vector: SETTLE_CYCLES+1 cycles. Last CHECK edge: E0+4*ITERATIONS*(SETTLE_CYCLES+1).
- DONE: one cycle. done=1, busy=0, pass=(final err_count==0), a,b hold last vector. Next edge goes to IDLE.
- pass, err_count and fail_vec hold until the next accepted start or reset.
- start while busy, during DONE, or held continuously: ignored except when sampled in IDLE. Held start re-triggers on the first IDLE cycle.
- Expected: and=a&b, or=a|b, xor=a^b, nand, nor, xnor are the complements, not_a=~a, not_b=~b.

Optional Feature:
GATE_EXERCISER_STOP_ON_FAIL_EN:
- Defined: a CHECK with any mismatch transitions directly to DONE, after updating err_count and fail_vec. a,b keep the failing vector.
- Undefined: all vectors always run to completion.

Decomposition:
- Package gate_exerciser_pkg: state enum; resp_in bit-index constants (AND_IDX=0 … NOT_B_IDX=7); function gate_expected(a,b) returning the 8-bit golden vector.
- No sub-module: the golden model is a package function; the FSM, counters and compare stay in one module.

Test Plan:
- Correct gate block, SETTLE=2, ITER=1: start pulse -> {a,b}=00,01,10,11 each held 3 cycles; done at E0+12; pass=1, err_count=0, fail_vec=8'h00.
- resp_in[2] forced 0: xor mismatches at 01 and 10 -> err_count=2, fail_vec=8'h04, pass=0.
- ITER=2, ERR_W=2, resp_in = ~golden: 8 failing checks -> err_count saturates at 3, fail_vec=8'hFF, done at E0+24.
- start held high through the run and pulsed on the done cycle -> one run only, then immediate rerun from IDLE. The rerun clears err_count/fail_vec at acceptance.
- rst during SETTLE of vector 10 -> next cycle a=b=0, busy=0, no done pulse, counters 0. A following start completes a clean sweep with pass=1.
- STOP_ON_FAIL_EN defined, resp_in[0] forced 1: fail at first CHECK (vector 00) -> done at E0+3, err_count=1, fail_vec=8'h01, {a,b}=00.

Source files
------------

// File: rtl/gate_exerciser_pkg.sv
// Shared types and golden model for the basic-gate exerciser.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package gate_exerciser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Bit positions of each gate output within resp_in / fail_vec.
    localparam int AND_IDX   = 0;
    localparam int OR_IDX    = 1;
    localparam int XOR_IDX   = 2;
    localparam int NAND_IDX  = 3;
    localparam int NOR_IDX   = 4;
    localparam int XNOR_IDX  = 5;
    localparam int NOT_A_IDX = 6;
    localparam int NOT_B_IDX = 7;

    // Golden truth table of the two-input gate block for one input vector.
    function automatic logic [7:0] gate_expected(input logic a, input logic b);
        logic [7:0] v;
        v            = '0;
        v[AND_IDX]   = a & b;
        v[OR_IDX]    = a | b;
        v[XOR_IDX]   = a ^ b;
        v[NAND_IDX]  = ~(a & b);
        v[NOR_IDX]   = ~(a | b);
        v[XNOR_IDX]  = ~(a ^ b);
        v[NOT_A_IDX] = ~a;
        v[NOT_B_IDX] = ~b;
        return v;
    endfunction

endpackage

// File: rtl/gate_exerciser.sv
// Sweeps a,b over 00,01,10,11 (ITERATIONS times), compares gate outputs to golden.
// Latency: 4*ITERATIONS*(SETTLE_CYCLES+1) cycles from start acceptance to done pulse.
// Backpressure: none; start is only sampled in IDLE. Option: GATE_EXERCISER_STOP_ON_FAIL_EN.
module gate_exerciser
    import gate_exerciser_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ITERATIONS    = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic [7:0]       resp_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       fail_vec
);

    localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int ITER_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ITER_W-1:0] SWEEP_LAST = ITER_W'(ITERATIONS - 1);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("gate_exerciser: SETTLE_CYCLES must be >= 1");
    end
    if (ITERATIONS < 1) begin : g_bad_iter
        $error("gate_exerciser: ITERATIONS must be >= 1");
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [ITER_W-1:0] sweep_q, sweep_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [7:0]        fail_q, fail_d;
    logic              pass_q, pass_d;
    logic [7:0]        mismatch;
    logic              run_end;

    // The vector index is the stimulus itself: {a,b} = idx.
    assign a         = idx_q[1];
    assign b         = idx_q[0];
    assign busy      = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

    // State and result registers; reset aborts any run without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sweep_q <= '0;
            err_q   <= '0;
            fail_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sweep_q <= sweep_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state logic: settle timing, compare, saturating error count, sticky flags.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        sweep_d  = sweep_q;
        err_d    = err_q;
        fail_d   = fail_q;
        pass_d   = pass_q;
        mismatch = resp_in ^ gate_expected(idx_q[1], idx_q[0]);
        run_end  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    sweep_d = '0;
                    err_d   = '0;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CHECK: begin
                if (|mismatch) begin
                    err_d  = (&err_q) ? err_q : err_q + ERR_W'(1);
                    fail_d = fail_q | mismatch;
                end
                run_end = (idx_q == 2'd3) && (sweep_q == SWEEP_LAST);
`ifdef GATE_EXERCISER_STOP_ON_FAIL_EN
                // First failing vector ends the run and stays on a,b for debug.
                run_end = run_end || (|mismatch);
`endif
                if (run_end) begin
                    state_d = ST_DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = ST_SETTLE;
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        sweep_d = sweep_q + ITER_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
